// File: rtl/dvb_plheader_mapper.sv
// DVB-S2 PL header mapper: 26-bit SOF plus a 64-bit PLS codeword, pi/2-BPSK mapped to 90 I/Q symbols.
// A one-deep pending buffer lets the next codeword be accepted during emission, so headers are gapless.
module dvb_plheader_mapper #(
    parameter int pTAG_W = 4,
    parameter int pDAT_W = 8,
    parameter int pAMP   = 90
) (
    input  logic                     iclk,
    input  logic                     ireset_n,
    input  logic                     iclkena,
    input  logic                     ival,
    input  logic [63:0]              idat,
    input  logic [pTAG_W-1:0]        itag,
    output logic                     ordy,
    input  logic                     ireq,
    output logic                     osop,
    output logic                     oval,
    output logic                     oeop,
    output logic signed [pDAT_W-1:0] odat_re,
    output logic signed [pDAT_W-1:0] odat_im,
    output logic [pTAG_W-1:0]        otag
);

    localparam logic [0:0]               cIDLE = 1'b0;
    localparam logic [0:0]               cRUN  = 1'b1;
    localparam logic [25:0]              cSOF  = 26'h18D2E82;
    localparam logic [6:0]               cLAST = 7'd89;
    localparam logic signed [pDAT_W-1:0] cAP   = pDAT_W'(pAMP);
    localparam logic signed [pDAT_W-1:0] cAN   = -cAP;

    logic [0:0]        state_q, state_d;
    logic [6:0]        k_q, k_d;
    logic              pend_full_q, pend_full_d;
    logic [63:0]       act_word_q, act_word_d, pend_word_q, pend_word_d;
    logic [pTAG_W-1:0] act_tag_q, act_tag_d, pend_tag_q, pend_tag_d;

    logic       acc, emit, last;
    logic [4:0] sof_idx;
    logic [5:0] wrd_idx;
    logic       ybit;

    assign ordy = ~pend_full_q;
    assign acc  = ival & ordy & iclkena;
    assign emit = (state_q == cRUN) & ireq & iclkena;
    assign last = emit & (k_q == cLAST);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        pend_full_d = pend_full_q;
        act_word_d  = act_word_q;
        act_tag_d   = act_tag_q;
        pend_word_d = pend_word_q;
        pend_tag_d  = pend_tag_q;
        if (state_q == cIDLE) begin
            if (acc) begin
                state_d    = cRUN;
                k_d        = '0;
                act_word_d = idat;
                act_tag_d  = itag;
            end
        end else begin
            if (emit) begin
                if (last) begin
                    k_d = '0;
                    if (pend_full_q) begin
                        act_word_d  = pend_word_q;
                        act_tag_d   = pend_tag_q;
                        pend_full_d = 1'b0;
                    end else if (acc) begin
                        act_word_d = idat;
                        act_tag_d  = itag;
                    end else begin
                        state_d = cIDLE;
                    end
                end else begin
                    k_d = k_q + 7'd1;
                end
            end
            // A word arriving on the final symbol with nothing pending goes straight to active.
            if (acc && !(last && !pend_full_q)) begin
                pend_word_d = idat;
                pend_tag_d  = itag;
                pend_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q     <= cIDLE;
            k_q         <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            pend_full_q <= pend_full_d;
        end
    end

    always_ff @(posedge iclk) begin
        act_word_q  <= act_word_d;
        act_tag_q   <= act_tag_d;
        pend_word_q <= pend_word_d;
        pend_tag_q  <= pend_tag_d;
    end

    // SOF is sent MSB first, the codeword LSB first.
    assign sof_idx = 5'd25 - k_q[4:0];
    assign wrd_idx = 6'(k_q - 7'd26);
    assign ybit    = (k_q < 7'd26) ? cSOF[sof_idx] : act_word_q[wrd_idx];

    assign oval    = emit;
    assign osop    = emit & (k_q == 7'd0);
    assign oeop    = last;
    assign odat_im = !emit ? '0 : (ybit ? cAN : cAP);
    assign odat_re = !emit ? '0 : ((ybit ^ k_q[0]) ? cAN : cAP);
    assign otag    = (state_q == cRUN) ? act_tag_q : '0;

endmodule

// File: tb/tb_dvb_plheader_mapper.sv
// Bench for dvb_plheader_mapper: directed vector table, hand sequences and a random run against a queue model.
module tb_dvb_plheader_mapper;

    localparam int TW = 4;
    localparam int DW = 8;
    localparam int A  = 90;

    logic          iclk = 1'b0, ireset_n = 1'b0, iclkena = 1'b0, ival = 1'b0, ireq = 1'b0;
    logic [63:0]   idat = '0;
    logic [TW-1:0] itag = '0;
    logic          ordy, osop, oval, oeop;
    logic signed [DW-1:0] odat_re, odat_im;
    logic [TW-1:0] otag;

    dvb_plheader_mapper #(.pTAG_W(TW), .pDAT_W(DW), .pAMP(A)) dut (
        .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .ival(ival), .idat(idat), .itag(itag),
        .ordy(ordy), .ireq(ireq), .osop(osop), .oval(oval), .oeop(oeop),
        .odat_re(odat_re), .odat_im(odat_im), .otag(otag)
    );

    always #5 iclk = ~iclk;

    typedef struct { logic [63:0] w; logic [TW-1:0] t; } hdr_t;
    typedef struct { int re; int im; logic sop; logic eop; logic [TW-1:0] tag; int cyc; } sym_t;
    typedef struct { logic [63:0] w; logic [TW-1:0] t; int k; int re; int im; } vec_t;

    hdr_t q[$];
    sym_t lg[$];
    int   pos = 0, cyc = 0, nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int ybit(input logic [63:0] w, input int k);
        logic [25:0] sof;
        sof = 26'h18D2E82;
        return (k < 26) ? int'(sof[25-k]) : int'(w[k-26]);
    endfunction

    // BPSK point (1-2y)(1+j)A, rotated by j on odd symbols.
    task automatic refsym(input logic [63:0] w, input int k, output int re, output int im);
        int s, t;
        s  = ybit(w, k) ? -A : A;
        re = s;
        im = s;
        if (k % 2 == 1) begin
            t  = re;
            re = -im;
            im = t;
        end
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic [TW-1:0] t, input logic rq,
                        input logic ce = 1'b1);
        logic e_rdy, e_val;
        int   ere, eim;
        ival = v; idat = d; itag = t; ireq = rq; iclkena = ce;
        @(negedge iclk);
        e_rdy = (q.size() < 2);
        e_val = (q.size() > 0) && rq && ce;
        ere = 0; eim = 0;
        if (e_val) refsym(q[0].w, pos, ere, eim);
        chk("ordy", ordy, e_rdy);
        chk("oval", oval, e_val);
        chk("osop", osop, e_val && pos == 0);
        chk("oeop", oeop, e_val && pos == 89);
        chk("re", $signed(odat_re), ere);
        chk("im", $signed(odat_im), eim);
        chk("otag", otag, (q.size() > 0) ? q[0].t : '0);
        if (oval) lg.push_back('{$signed(odat_re), $signed(odat_im), osop, oeop, otag, cyc});
        @(posedge iclk);
        if (e_val) begin
            pos++;
            if (pos == 90) begin
                void'(q.pop_front());
                pos = 0;
            end
        end
        if (v && e_rdy && ce) q.push_back('{d, t});
        cyc++;
        #1;
    endtask

    task automatic run(input int n, input logic tog);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, tog ? logic'(i % 2 == 0) : 1'b1);
    endtask

    task automatic do_reset();
        ival = 1'b0;
        #2 ireset_n = 1'b0;
        #1;
        chk("rst_ordy", ordy, 1);
        chk("rst_oval", oval, 0);
        chk("rst_osop", osop, 0);
        chk("rst_oeop", oeop, 0);
        chk("rst_re", $signed(odat_re), 0);
        chk("rst_im", $signed(odat_im), 0);
        q.delete();
        pos = 0;
        @(posedge iclk);
        #1 ireset_n = 1'b1;
    endtask

    vec_t vt[7];
    int   nsop, neop, ntag;

    initial begin
        vt[0] = '{64'h0, 4'd0, 0, A, A};
        vt[1] = '{64'h0, 4'd0, 1, A, -A};
        vt[2] = '{64'h0, 4'd0, 25, -A, A};
        vt[3] = '{64'h0, 4'd0, 26, A, A};
        vt[4] = '{64'h0, 4'd0, 27, -A, A};
        vt[5] = '{64'h1, 4'd5, 26, -A, -A};
        vt[6] = '{64'h8000_0000_0000_0000, 4'd9, 89, A, -A};

        // 1: reset state
        #1;
        chk("init_ordy", ordy, 1);
        chk("init_oval", oval, 0);
        @(posedge iclk);
        #1 ireset_n = 1'b1;
        run(3, 1'b0);

        // 2/3: single headers against the vector table
        for (int i = 0; i < 7; i++) begin
            lg.delete();
            step(1'b1, vt[i].w, vt[i].t, 1'b1);
            run(93, 1'b0);
            chk("hdr_len", lg.size(), 90);
            if (lg.size() == 90) begin
                chk("tbl_re", lg[vt[i].k].re, vt[i].re);
                chk("tbl_im", lg[vt[i].k].im, vt[i].im);
                chk("tbl_sop", lg[0].sop, 1);
                chk("tbl_eop", lg[89].eop, 1);
                ntag = 0;
                foreach (lg[j]) if (lg[j].tag == vt[i].t) ntag++;
                chk("tbl_tag", ntag, 90);
            end
        end

        // 4: back-to-back headers are gapless
        lg.delete();
        step(1'b1, 64'hDEAD_BEEF_0123_4567, 4'd1, 1'b1);
        step(1'b1, 64'h0F0F_F0F0_AAAA_5555, 4'd2, 1'b1);
        run(185, 1'b0);
        chk("b2b_len", lg.size(), 180);
        if (lg.size() == 180) begin
            chk("b2b_gap", lg[179].cyc - lg[0].cyc, 179);
            chk("b2b_sop2", lg[90].sop, 1);
            chk("b2b_tag1", lg[89].tag, 1);
            chk("b2b_tag2", lg[90].tag, 2);
        end

        // 5: toggled requests, third word dropped while pending is full
        lg.delete();
        step(1'b1, 64'h1111_2222_3333_4444, 4'd3, 1'b1);
        step(1'b1, 64'h5555_6666_7777_8888, 4'd4, 1'b0);
        chk("drop_ordy", ordy, 0);
        step(1'b1, 64'h9999_AAAA_BBBB_CCCC, 4'd5, 1'b1);
        run(400, 1'b1);
        nsop = 0; neop = 0;
        foreach (lg[j]) begin
            nsop += int'(lg[j].sop);
            neop += int'(lg[j].eop);
        end
        chk("tog_len", lg.size(), 180);
        chk("tog_sop", nsop, 2);
        chk("tog_eop", neop, 2);

        // 6: reset mid-header, next header restarts with SOF
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 1'b1);
        run(40, 1'b0);
        do_reset();
        lg.delete();
        step(1'b1, 64'h0123_4567_89AB_CDEF, 4'd6, 1'b1);
        run(5, 1'b0);
        chk("rst_len", lg.size(), 5);
        if (lg.size() == 5) begin
            chk("rst_sop", lg[0].sop, 1);
            chk("rst_k0re", lg[0].re, A);
            chk("rst_k1im", lg[1].im, -A);
        end
        run(90, 1'b0);

        // random traffic, clock enable and request gaps
        for (int i = 0; i < 4000; i++)
            step(logic'($urandom_range(3) == 0), {$urandom, $urandom}, TW'($urandom),
                 logic'($urandom_range(3) != 0), logic'($urandom_range(7) != 0));
        run(300, 1'b0);
        chk("drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
